// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC Machine control path.
// States, opcode/op fields, ALU operation and write-back codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/instr_decoder.sv
// Field extraction for a 16-bit instruction word.
// Purely combinational; sign-extends the 8-bit immediate.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
);

  // slice fixed instruction fields
  always_comb begin
    opcode = ir[15:13];
    op     = ir[12:11];
    rn     = ir[10:8];
    rd     = ir[7:5];
    shift  = ir[4:3];
    rm     = ir[2:0];
    sximm8 = {{8{ir[7]}}, ir[7:0]};
  end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle control FSM and instruction register.
// Sequences register reads, ALU execute and write-back.
module rf_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  state_t      state, state_n;
  logic [15:0] ir;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic [15:0] imm8;

  instr_decoder u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .shift  (sh),
    .sximm8 (imm8)
  );

  logic is_alu, is_mov_imm, is_mov_reg;
  logic is_add, is_cmp, is_and, is_mvn;

  assign is_alu     = (opcode == OPC_ALU);
  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_add     = is_alu && (op == OP_ADD);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_and     = is_alu && (op == OP_AND);
  assign is_mvn     = is_alu && (op == OP_MVN);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_n;
  end

  // IR captures a new word only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ir <= '0;
    else if (load && state == S_WAIT)  ir <= in;
  end

  // next state and Moore outputs
  always_comb begin
    state_n  = state;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = ALU_ADD;
    shift    = sh;
    sximm8   = imm8;
    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_n = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_mov_imm:                state_n = S_WRITE_IMM;
          is_mov_reg || is_mvn:      state_n = S_GET_B;
          is_add || is_and || is_cmp: state_n = S_GET_A;
          default:                   state_n = S_WAIT;
        endcase
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_n = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        asel = is_mov_reg || is_mvn;
        unique case (1'b1)
          is_cmp:  ALUop = ALU_CMP;
          is_and:  ALUop = ALU_AND;
          is_mvn:  ALUop = ALU_MVN;
          default: ALUop = ALU_ADD;
        endcase
        if (is_cmp) begin
          loads   = 1'b1;
          state_n = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_n = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_n  = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        state_n  = S_WAIT;
      end
      default: state_n = S_WAIT;
    endcase
  end

endmodule
